i3c_bus_input_filter: RTL and testbench
=======================================

Name: i3c_bus_input_filter

Overview:
- Conditions the raw SCL/SDA pad inputs before the I3C core's `scl_i`/`sda_i`, sitting between the pad cells and the I3C top wrapper.
- Resynchronises both lines, suppresses spikes with a programmable-length glitch filter, and detects SCL edges, START/Sr, STOP and bus-free (idle).
- The core consumes the filtered levels and event pulses.

Parameters:
- SyncStages, 2, number of flip-flops in each line's synchroniser chain (>=2).
- FilterCntWidth, 4, width of the spike-filter length input and counters.
- IdleCntWidth, 12, width of the bus-idle threshold input and counter.
- StatCntWidth, 16, width of each statistics counter (optional feature only).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, synchronous, active-low.
- scl_i  input  1  raw SCL from pad (asynchronous).
- sda_i  input  1  raw SDA from pad (asynchronous).
- filter_en_i  input  1  1 = spike filter active, 0 = bypass.
- filter_cycles_i  input  FilterCntWidth  spike-filter threshold N.
- idle_cycles_i  input  IdleCntWidth  bus-free threshold M.
- scl_o  output  1  filtered SCL.
- sda_o  output  1  filtered SDA.
- scl_posedge_o  output  1  one-cycle pulse on filtered SCL rise.
- scl_negedge_o  output  1  one-cycle pulse on filtered SCL fall.
- start_det_o  output  1  one-cycle pulse on START or repeated START.
- stop_det_o  output  1  one-cycle pulse on STOP.
- bus_idle_o  output  1  level; high when the bus is free.

Behaviour:
- Clock is `clk_i`. Reset `rst_ni` is synchronous and active-low, sampled on the `clk_i` rising edge.
- Reset values:
  - All synchroniser flops, `scl_o` and `sda_o` = 1 (pulled-up bus).
  - Filter counters = 0; idle counter = 0; previous-level registers = 1.
  - `bus_idle_o` = 0.
  - All pulse outputs = 0.
- Synchroniser: a SyncStages-deep flop chain per line produces `s_scl` and `s_sda`.
- Filter, per line, each cycle with `filter_en_i`=1:
  - If `s` != `out`: when `cnt` >= N, `out` <= `s` and `cnt` <= 0; otherwise `cnt` <= `cnt`+1.
  - If `s` == `out`: `cnt` <= 0.
  - A level must therefore persist N+1 consecutive synchronised cycles to propagate.
  - Pad-to-output latency is SyncStages+N+1 cycles.
  - `cnt` never exceeds N, so there is no overflow.
- Filter with `filter_en_i`=0: `out` <= `s` every cycle, latency SyncStages+1; `cnt` is held at 0.
- Changing N or `filter_en_i` mid-transition: the new value applies from the next cycle. Because of the `>=` compare, lowering N below `cnt` accepts the pending value on the next cycle.
- Edge and condition detection: registers `scl_q`/`sda_q` hold the previous-cycle `scl_o`/`sda_o`. Outputs are combinational from `scl_o`, `sda_o`, `scl_q`, `sda_q`:
  - `scl_posedge_o` = `scl_o` & !`scl_q`.
  - `scl_negedge_o` = !`scl_o` & `scl_q`.
  - `start_det_o` = `scl_o` & `scl_q` & !`sda_o` & `sda_q`.
  - `stop_det_o` = `scl_o` & `scl_q` & `sda_o` & !`sda_q`.
  - If SCL and SDA change in the same cycle, neither START nor STOP is reported, but the SCL edge pulse is reported.
- Idle detection, each cycle:
  - If !(`scl_o` & `sda_o`): idle counter <= 0 and `bus_idle_o` <= 0.
  - Else if counter >= M: `bus_idle_o` <= 1 and the counter holds (saturates).
  - Else: counter <= counter+1.
  - From reset with M=0, `bus_idle_o` rises 1 cycle after reset release.
  - A STOP followed by high lines asserts `bus_idle_o` M+1 cycles after `stop_det_o`.
  - A START clears `bus_idle_o` in the cycle after `start_det_o`.
- Reset mid-operation: all state returns to its reset values at the next clock edge; no pulses are generated by the reset-induced level change.

Optional Feature:
- Macro: `I3C_BUS_FILTER_STATS_EN`.
- When defined, the block adds these ports:
  - `stats_clr_i`  input  1  synchronous clear of all statistics counters.
  - `start_cnt_o`  output  StatCntWidth  count of START/Sr.
  - `stop_cnt_o`  output  StatCntWidth  count of STOP.
  - `glitch_cnt_o`  output  StatCntWidth  count of rejected spikes.
- A rejected spike is counted on any cycle, for either line, where `cnt` > 0 and `s` == `out`. If both lines reject in the same cycle, the count increments by 2.
- All statistics counters:
  - Saturate at all-ones.
  - Reset to 0.
  - Are cleared by `stats_clr_i`, which has priority over a same-cycle increment.
- When the macro is undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then hold pads high with M=10 → `scl_o`=`sda_o`=1, no pulses, `bus_idle_o` rises 11 cycles after reset release.
- Filter on, N=3, SyncStages=2, 3-cycle low spike on SDA → `sda_o` stays 1, no `start_det_o`. A 4-cycle low appears on `sda_o` 6 cycles after the pad edge; with the stats macro, `glitch_cnt_o`=1 after the first spike.
- SCL high, SDA falls (filter bypassed) → `start_det_o` one-cycle pulse exactly 3 cycles after the pad edge, and `bus_idle_o` clears the following cycle.
- SCL high, SDA rises, M=5 → one `stop_det_o` pulse; `bus_idle_o`=1 six cycles later. A SCL 0→1 toggle produces `scl_posedge_o` only.
- SCL and SDA fall on the same pad cycle → `scl_negedge_o` pulses, `start_det_o` stays 0.
- `rst_ni` low mid-filter count (`cnt`=2), then release → `cnt`=0, outputs=1, no pulses. With the stats macro, `stats_clr_i` coincident with a START leaves `start_cnt_o`=0.

Source files
------------

// File: rtl/i3c_bus_input_filter.sv
// SCL/SDA pad conditioning: synchroniser, spike filter, edge/START/STOP/idle detect.
// Optional statistics counters are enabled with the I3C_BUS_FILTER_STATS_EN macro.
module i3c_bus_input_filter #(
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned FilterCntWidth = 4,
    parameter int unsigned IdleCntWidth   = 12,
    parameter int unsigned StatCntWidth   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      scl_i,
    input  logic                      sda_i,
    input  logic                      filter_en_i,
    input  logic [FilterCntWidth-1:0] filter_cycles_i,
    input  logic [IdleCntWidth-1:0]   idle_cycles_i,
`ifdef I3C_BUS_FILTER_STATS_EN
    input  logic                      stats_clr_i,
    output logic [StatCntWidth-1:0]   start_cnt_o,
    output logic [StatCntWidth-1:0]   stop_cnt_o,
    output logic [StatCntWidth-1:0]   glitch_cnt_o,
`endif
    output logic                      scl_o,
    output logic                      sda_o,
    output logic                      scl_posedge_o,
    output logic                      scl_negedge_o,
    output logic                      start_det_o,
    output logic                      stop_det_o,
    output logic                      bus_idle_o
);

    logic [SyncStages-1:0]          scl_sync_q;
    logic [SyncStages-1:0]          scl_sync_d;
    logic [SyncStages-1:0]          sda_sync_q;
    logic [SyncStages-1:0]          sda_sync_d;
    logic [1:0]                     s_lvl;
    logic [1:0]                     out_q;
    logic [1:0]                     out_d;
    logic [1:0][FilterCntWidth-1:0] cnt_q;
    logic [1:0][FilterCntWidth-1:0] cnt_d;
    logic [1:0]                     prev_q;
    logic [1:0]                     prev_d;
    logic [IdleCntWidth-1:0]        idle_cnt_q;
    logic [IdleCntWidth-1:0]        idle_cnt_d;
    logic                           bus_idle_q;
    logic                           bus_idle_d;

    // Index 0 is SCL, index 1 is SDA throughout.
    assign scl_sync_d = {scl_sync_q[SyncStages-2:0], scl_i};
    assign sda_sync_d = {sda_sync_q[SyncStages-2:0], sda_i};
    assign s_lvl      = {sda_sync_q[SyncStages-1], scl_sync_q[SyncStages-1]};

    always_comb begin
        out_d = out_q;
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (!filter_en_i) begin
                out_d[i] = s_lvl[i];
            end else if (s_lvl[i] != out_q[i]) begin
                if (cnt_q[i] >= filter_cycles_i) begin
                    out_d[i] = s_lvl[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign prev_d = out_q;

    assign scl_o         = out_q[0];
    assign sda_o         = out_q[1];
    assign scl_posedge_o = out_q[0] & ~prev_q[0];
    assign scl_negedge_o = ~out_q[0] & prev_q[0];
    assign start_det_o   = out_q[0] & prev_q[0] & ~out_q[1] & prev_q[1];
    assign stop_det_o    = out_q[0] & prev_q[0] & out_q[1] & ~prev_q[1];
    assign bus_idle_o    = bus_idle_q;

    // Counter saturates once the threshold is met so idle stays latched.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        bus_idle_d = bus_idle_q;
        if (!(out_q[0] & out_q[1])) begin
            idle_cnt_d = '0;
            bus_idle_d = 1'b0;
        end else if (idle_cnt_q >= idle_cycles_i) begin
            bus_idle_d = 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            out_q      <= 2'b11;
            cnt_q      <= '0;
            prev_q     <= 2'b11;
            idle_cnt_q <= '0;
            bus_idle_q <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            out_q      <= out_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            idle_cnt_q <= idle_cnt_d;
            bus_idle_q <= bus_idle_d;
        end
    end

`ifdef I3C_BUS_FILTER_STATS_EN
    localparam logic [StatCntWidth-1:0] StatMax = '1;

    logic [1:0]              reject;
    logic [1:0]              glitch_inc;
    logic [StatCntWidth-1:0] start_cnt_q;
    logic [StatCntWidth-1:0] start_cnt_d;
    logic [StatCntWidth-1:0] stop_cnt_q;
    logic [StatCntWidth-1:0] stop_cnt_d;
    logic [StatCntWidth-1:0] glitch_cnt_q;
    logic [StatCntWidth-1:0] glitch_cnt_d;

    // A spike was rejected when a pending count collapses back to the output level.
    assign reject[0]  = (cnt_q[0] != '0) && (s_lvl[0] == out_q[0]);
    assign reject[1]  = (cnt_q[1] != '0) && (s_lvl[1] == out_q[1]);
    assign glitch_inc = {1'b0, reject[0]} + {1'b0, reject[1]};

    always_comb begin
        start_cnt_d  = start_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        glitch_cnt_d = glitch_cnt_q;
        if (stats_clr_i) begin
            start_cnt_d  = '0;
            stop_cnt_d   = '0;
            glitch_cnt_d = '0;
        end else begin
            if (start_det_o && (start_cnt_q != StatMax)) begin
                start_cnt_d = start_cnt_q + 1'b1;
            end
            if (stop_det_o && (stop_cnt_q != StatMax)) begin
                stop_cnt_d = stop_cnt_q + 1'b1;
            end
            if (glitch_cnt_q > (StatMax - StatCntWidth'(glitch_inc))) begin
                glitch_cnt_d = StatMax;
            end else begin
                glitch_cnt_d = glitch_cnt_q + StatCntWidth'(glitch_inc);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            start_cnt_q  <= '0;
            stop_cnt_q   <= '0;
            glitch_cnt_q <= '0;
        end else begin
            start_cnt_q  <= start_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign start_cnt_o  = start_cnt_q;
    assign stop_cnt_o   = stop_cnt_q;
    assign glitch_cnt_o = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_i3c_bus_input_filter.sv
// Randomised and directed bench for i3c_bus_input_filter against a run-length model.
module tb_i3c_bus_input_filter;
    localparam int SS = 2;
    localparam int FW = 4;
    localparam int IW = 12;
    localparam int SW = 16;
    localparam int LOGSZ = 16384;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scl = 1'b1;
    logic          sda = 1'b1;
    logic          en = 1'b0;
    logic [FW-1:0] ncyc = '0;
    logic [IW-1:0] mcyc = 12'd10;
    logic          scl_o, sda_o, pos, neg, st, sp, idle;
`ifdef I3C_BUS_FILTER_STATS_EN
    logic          clr = 1'b0;
    logic [SW-1:0] scnt, pcnt, gcnt;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    i3c_bus_input_filter #(
        .SyncStages(SS), .FilterCntWidth(FW), .IdleCntWidth(IW), .StatCntWidth(SW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .scl_i(scl), .sda_i(sda),
        .filter_en_i(en), .filter_cycles_i(ncyc), .idle_cycles_i(mcyc),
`ifdef I3C_BUS_FILTER_STATS_EN
        .stats_clr_i(clr), .start_cnt_o(scnt), .stop_cnt_o(pcnt), .glitch_cnt_o(gcnt),
`endif
        .scl_o(scl_o), .sda_o(sda_o), .scl_posedge_o(pos), .scl_negedge_o(neg),
        .start_det_o(st), .stop_det_o(sp), .bus_idle_o(idle)
    );

    // Model: pads are logged per edge; the synchronised level is the pad value
    // seen SS edges earlier (or high if that predates the last reset). Each line
    // tracks how many consecutive cycles the synchronised level has disagreed.
    bit [1:0] padlog [0:LOGSZ-1];
    int       cyc = 0;
    int       lastrst = 0;
    bit [1:0] mo = 2'b11;
    bit [1:0] mp = 2'b11;
    int       mrun [2] = '{0, 0};
    bit       midle = 1'b0;
    int       mhigh = 0;
    int       ms = 0, mpc = 0, mg = 0;
    bit [1:0] t_s, t_no;
    int       t_nr [2];
    int       t_rej;

    wire m_pos   = mo[0] & ~mp[0];
    wire m_neg   = ~mo[0] & mp[0];
    wire m_start = mo[0] & mp[0] & ~mo[1] & mp[1];
    wire m_stop  = mo[0] & mp[0] & mo[1] & ~mp[1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc < LOGSZ) padlog[cyc] <= {sda, scl};
        if (!rst_n) begin
            lastrst <= cyc;
            mo <= 2'b11;
            mp <= 2'b11;
            mrun <= '{0, 0};
            midle <= 1'b0;
            mhigh <= 0;
            ms <= 0;
            mpc <= 0;
            mg <= 0;
        end else begin
            t_s = (cyc - SS > lastrst) ? padlog[cyc - SS] : 2'b11;
            t_rej = 0;
            for (int i = 0; i < 2; i++) begin
                t_no[i] = mo[i];
                t_nr[i] = 0;
                if (t_s[i] == mo[i]) begin
                    if (mrun[i] > 0) t_rej = t_rej + 1;
                end else if (!en) begin
                    t_no[i] = t_s[i];
                end else if (mrun[i] + 1 >= int'(ncyc) + 1) begin
                    t_no[i] = t_s[i];
                end else begin
                    t_nr[i] = mrun[i] + 1;
                end
            end
            mo <= t_no;
            mp <= mo;
            mrun <= t_nr;
            if (mo != 2'b11) begin
                mhigh <= 0;
                midle <= 1'b0;
            end else if (mhigh >= int'(mcyc)) begin
                midle <= 1'b1;
            end else begin
                mhigh <= mhigh + 1;
            end
`ifdef I3C_BUS_FILTER_STATS_EN
            if (clr) begin
                ms <= 0;
                mpc <= 0;
                mg <= 0;
            end else begin
                if (m_start && ms < SMAX) ms <= ms + 1;
                if (m_stop && mpc < SMAX) mpc <= mpc + 1;
                mg <= (mg + t_rej > SMAX) ? SMAX : mg + t_rej;
            end
`endif
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("scl_o", 32'(scl_o), 32'(mo[0]));
            check("sda_o", 32'(sda_o), 32'(mo[1]));
            check("scl_posedge", 32'(pos), 32'(m_pos));
            check("scl_negedge", 32'(neg), 32'(m_neg));
            check("start_det", 32'(st), 32'(m_start));
            check("stop_det", 32'(sp), 32'(m_stop));
            check("bus_idle", 32'(idle), 32'(midle));
`ifdef I3C_BUS_FILTER_STATS_EN
            check("start_cnt", 32'(scnt), ms);
            check("stop_cnt", 32'(pcnt), mpc);
            check("glitch_cnt", 32'(gcnt), mg);
`endif
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        step(2);
        chk_en = 1'b1;
        check("rst_scl", 32'(scl_o), 1);
        check("rst_sda", 32'(sda_o), 1);
        check("rst_idle", 32'(idle), 0);
        check("rst_pulses", {28'd0, pos, neg, st, sp}, 0);

        rst_n = 1'b1;
        step(10);
        check("idle_m10_early", 32'(idle), 0);
        step(1);
        check("idle_m10_rise", 32'(idle), 1);
        check("model_idle_pin", 32'(midle), 1);

        en = 1'b1;
        ncyc = 4'd3;
        sda = 1'b0;
        step(3);
        sda = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            check("spike_sda_held", 32'(sda_o), 1);
            check("spike_no_start", 32'(st), 0);
        end
`ifdef I3C_BUS_FILTER_STATS_EN
        check("spike_glitch_cnt", 32'(gcnt), 1);
`endif
        sda = 1'b0;
        step(4);
        sda = 1'b1;
        step(1);
        check("long_sda_early", 32'(sda_o), 1);
        step(1);
        check("long_sda_fall", 32'(sda_o), 0);
        check("model_sda_pin", 32'(mo[1]), 0);
        check("long_start", 32'(st), 1);
        step(8);
        step(15);

        en = 1'b0;
        sda = 1'b0;
        step(2);
        check("start_early", 32'(st), 0);
        step(1);
        check("start_pulse", 32'(st), 1);
        check("idle_before_clear", 32'(idle), 1);
        step(1);
        check("idle_cleared", 32'(idle), 0);
        check("start_once", 32'(st), 0);

        mcyc = 12'd5;
        sda = 1'b1;
        step(3);
        check("stop_pulse", 32'(sp), 1);
        step(5);
        check("stop_idle_early", 32'(idle), 0);
        step(1);
        check("stop_idle_rise", 32'(idle), 1);

        scl = 1'b0;
        step(4);
        scl = 1'b1;
        step(3);
        check("scl_pos", 32'(pos), 1);
        check("scl_pos_only", {29'd0, neg, st, sp}, 0);
        step(3);

        scl = 1'b0;
        sda = 1'b0;
        step(3);
        check("both_neg", 32'(neg), 1);
        check("both_no_start", 32'(st), 0);
        scl = 1'b1;
        step(5);
        sda = 1'b1;
        step(5);

        en = 1'b1;
        ncyc = 4'd3;
        sda = 1'b0;
        step(4);
        rst_n = 1'b0;
        sda = 1'b1;
        step(1);
        check("midrst_sda", 32'(sda_o), 1);
        check("midrst_idle", 32'(idle), 0);
        check("midrst_pulses", {28'd0, pos, neg, st, sp}, 0);
        rst_n = 1'b1;
        step(1);
        check("postrst_sda", 32'(sda_o), 1);
        check("postrst_pulses", {28'd0, pos, neg, st, sp}, 0);

`ifdef I3C_BUS_FILTER_STATS_EN
        en = 1'b0;
        step(10);
        sda = 1'b0;
        step(5);
        check("first_start_cnt", 32'(scnt), 1);
        sda = 1'b1;
        step(10);
        sda = 1'b0;
        step(3);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clr_start_cnt", 32'(scnt), 0);
        sda = 1'b1;
        step(5);
`endif

        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 2500; i++) begin
                @(negedge clk);
                if ($urandom_range(0, ph == 0 ? 5 : 40) == 0) scl = ~scl;
                if ($urandom_range(0, ph == 0 ? 5 : 40) == 0) sda = ~sda;
                if ($urandom_range(0, 40) == 0) en = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 40) == 0) ncyc = FW'($urandom_range(0, 5));
                if ($urandom_range(0, 60) == 0) mcyc = IW'($urandom_range(0, 20));
                rst_n = ($urandom_range(0, 400) != 0);
`ifdef I3C_BUS_FILTER_STATS_EN
                clr = ($urandom_range(0, 150) == 0);
`endif
            end
        end
        rst_n = 1'b1;
        step(2);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
